imem_loader: RTL and testbench
==============================

// Module: imem_loader
// PURPOSE
//  Boot-time writer for instruction SRAM: receives a program as a byte stream (valid/ready),
//  packs bytes into 32-bit words, writes them from BASE_ADDR upward, then releases the core.
//  Sits between the external boot/debug link and the instruction SRAM write port.
//  Drives start_up into instruction fetch: the core is held at the boot PC until the load completes.
// PARAMETERS
//  BASE_ADDR  32'h0040_0020  byte address of the first program word; must be word-aligned
//  CNT_W      16             width of word_count and of the internal word index
// PORTS
//  clk         in   1      system clock, rising edge
//  rst_n       in   1      asynchronous active-low reset
//  load_req    in   1      1-cycle pulse that starts a load; ignored unless the FSM is in IDLE
//  word_count  in   CNT_W  number of program words; sampled when load_req is accepted
//  byte_valid  in   1      byte_data is valid
//  byte_data   in   8      stream byte; big-endian, first byte goes to word[31:24]
//  byte_ready  out  1      loader accepts the byte; a transfer occurs when byte_valid & byte_ready
//  mem_we      out  1      SRAM write enable, 1 cycle per word
//  mem_addr    out  32     SRAM byte address = BASE_ADDR + (word_idx << 2), 32-bit wrap
//  mem_din     out  32     packed word to write
//  start_up    out  1      1 = hold fetch PC at the boot address
//  busy        out  1      1 in every state except IDLE
//  cksum_err   out  1      sticky checksum mismatch flag; constant 0 without the macro
// BEHAVIOUR
//  Reset values: byte_ready=0, mem_we=0, mem_addr=BASE_ADDR, mem_din=0, start_up=1, busy=0,
//    cksum_err=0, state=IDLE, byte counter=0, word_idx=0.
//  States: IDLE, RECV, WRITE, (CHECK), FINISH.
//  IDLE:   byte_ready=0. On load_req: latch word_count, clear word_idx, byte counter and cksum_err.
//          Go to FINISH if word_count==0, else to RECV.
//  RECV:   byte_ready=1. Each transfer shifts byte_data into the packer (word = {word[23:0], byte}).
//          On the 4th byte, go to WRITE (or CHECK when receiving the checksum word).
//  WRITE:  exactly 1 cycle. mem_we=1, mem_addr/mem_din valid, byte_ready=0; word_idx increments.
//          If word_idx+1 == latched count, go to FINISH (or to RECV for the checksum word); else RECV.
//  FINISH: 1 cycle, start_up=1 (fetch loads the boot PC on this edge). Then IDLE with start_up=0,
//          unless cksum_err is set, in which case start_up stays 1.
//  start_up is 1 from reset until the first successful FINISH, and is 1 again during any later load.
//  Latency: 4 accepted bytes -> mem_we on the next cycle. Sustained rate is 4 bytes per 5 cycles.
//  Boundaries:
//   - load_req while busy: ignored, with no effect on the latched count.
//   - byte_valid low mid-word: the packer holds its partial word indefinitely.
//   - byte_valid in IDLE/WRITE/FINISH: not accepted, because byte_ready=0.
//   - rst_n low mid-load: immediate return to reset values; the partial word is discarded and never written.
//   - mem_addr wraps modulo 2^32. word_count up to 2^CNT_W-1 is supported.
// CONFIGURATION
//  IMEM_LOADER_CHECKSUM_EN defined:
//   - A 32-bit wrapping sum of all written words is accumulated during the load.
//   - After the last data word, 4 more bytes form the checksum word, which is not written to SRAM.
//   - CHECK (1 cycle): if the sum != the checksum word, cksum_err is set; then go to FINISH.
//   - cksum_err clears on the next accepted load_req.
//  IMEM_LOADER_CHECKSUM_EN undefined: no CHECK state and no checksum bytes; cksum_err tied to 0.
// STRUCTURE
//  Shared include lib/imem_defs.v: state encodings (IDLE..FINISH), BOOT_ADDR 32'h0040_0020,
//    and the word width constant, reused by the fetch/SRAM side.
//  One sub-module: byte_packer (4-byte shift register, 2-bit counter, word_done pulse, sync clear).
//  Top level: FSM, word_idx counter, address adder, and the optional checksum accumulator.
// TESTING
//  1. Reset; load_req with word_count=2; bytes 12 34 56 78 9A BC DE F0 ->
//     mem_we at 0x00400020 = 0x12345678, then at 0x00400024 = 0x9ABCDEF0; start_up 1->0 after FINISH.
//  2. load_req with word_count=0 -> no mem_we; FINISH after 1 cycle, then start_up=0; byte_ready stays 0.
//  3. word_count=1, byte_valid toggled every other cycle -> one write 0xAABBCCDD, gaps tolerated;
//     second load_req mid-load is ignored (exactly 1 write).
//  4. Assert rst_n low after 3 bytes of word 0 -> no mem_we; all outputs at reset values; start_up=1.
//  5. With checksum: word_count=2, words 0x00000001, 0x00000002, checksum 0x00000003 -> cksum_err=0,
//     start_up=0. Same data with checksum 0x00000004 -> cksum_err=1, start_up stays 1.
//  6. Checksum off: stream 8 bytes, word_count=2 -> exactly 2 writes; cksum_err constantly 0.

Source files
------------

// File: rtl/imem_loader_pkg.sv
// Shared loader definitions: FSM state encodings, boot address and word width.
// The CHECK state exists only when IMEM_LOADER_CHECKSUM_EN is defined.
package imem_loader_pkg;

  localparam int unsigned WORD_W    = 32;
  localparam logic [31:0] BOOT_ADDR = 32'h0040_0020;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RECV   = 3'd1,
    ST_WRITE  = 3'd2,
`ifdef IMEM_LOADER_CHECKSUM_EN
    ST_CHECK  = 3'd3,
`endif
    ST_FINISH = 3'd4
  } state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Big-endian byte-to-word packer: four shifted bytes form one word, first byte lands in [31:24].
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              clr_i,
  input  logic              shift_i,
  input  logic [7:0]        byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic              word_done_o
);

  logic [WORD_W-1:0] word_q, word_d;
  logic [1:0]        cnt_q, cnt_d;

  always_comb begin
    word_d = word_q;
    cnt_d  = cnt_q;
    if (clr_i) begin
      word_d = '0;
      cnt_d  = '0;
    end else if (shift_i) begin
      word_d = {word_q[WORD_W-9:0], byte_i};
      cnt_d  = cnt_q + 2'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      word_q <= '0;
      cnt_q  <= '0;
    end else begin
      word_q <= word_d;
      cnt_q  <= cnt_d;
    end
  end

  assign word_o      = word_q;
  assign word_done_o = shift_i && !clr_i && (cnt_q == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Boot loader: streams program bytes into instruction SRAM and holds the core until done.
// Optional trailing checksum word verification when IMEM_LOADER_CHECKSUM_EN is defined.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = BOOT_ADDR,
  parameter int unsigned CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load_req,
  input  logic [CNT_W-1:0] word_count,
  input  logic             byte_valid,
  input  logic [7:0]       byte_data,
  output logic             byte_ready,
  output logic             mem_we,
  output logic [31:0]      mem_addr,
  output logic [31:0]      mem_din,
  output logic             start_up,
  output logic             busy,
  output logic             cksum_err
);

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  idx_q, idx_d, idx_inc;
  logic              start_up_q, start_up_d;
  logic              pk_clr, pk_shift, pk_done;
  logic [WORD_W-1:0] pk_word;
  logic [31:0]       idx_ext;
`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [31:0]       sum_q, sum_d;
  logic              cks_phase_q, cks_phase_d;
  logic              cksum_err_q, cksum_err_d;
`endif

  assign pk_shift = byte_valid && (state_q == ST_RECV);
  assign pk_clr   = load_req && (state_q == ST_IDLE);
  assign idx_inc  = idx_q + {{(CNT_W-1){1'b0}}, 1'b1};

  imem_loader_byte_packer u_packer (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .clr_i       (pk_clr),
    .shift_i     (pk_shift),
    .byte_i      (byte_data),
    .word_o      (pk_word),
    .word_done_o (pk_done)
  );

  always_comb begin
    state_d    = state_q;
    count_d    = count_q;
    idx_d      = idx_q;
    start_up_d = start_up_q;
`ifdef IMEM_LOADER_CHECKSUM_EN
    sum_d       = sum_q;
    cks_phase_d = cks_phase_q;
    cksum_err_d = cksum_err_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (load_req) begin
          count_d    = word_count;
          idx_d      = '0;
          start_up_d = 1'b1;
`ifdef IMEM_LOADER_CHECKSUM_EN
          sum_d       = '0;
          cks_phase_d = 1'b0;
          cksum_err_d = 1'b0;
`endif
          state_d = (word_count == '0) ? ST_FINISH : ST_RECV;
        end
      end
      ST_RECV: begin
        if (pk_done) begin
`ifdef IMEM_LOADER_CHECKSUM_EN
          state_d = cks_phase_q ? ST_CHECK : ST_WRITE;
`else
          state_d = ST_WRITE;
`endif
        end
      end
      ST_WRITE: begin
        idx_d   = idx_inc;
        state_d = ST_RECV;
`ifdef IMEM_LOADER_CHECKSUM_EN
        sum_d = sum_q + pk_word;
        // Last data word: stay in RECV to collect the checksum word instead of finishing.
        if (idx_inc == count_q) cks_phase_d = 1'b1;
`else
        if (idx_inc == count_q) state_d = ST_FINISH;
`endif
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      ST_CHECK: begin
        if (sum_q != pk_word) cksum_err_d = 1'b1;
        state_d = ST_FINISH;
      end
`endif
      ST_FINISH: begin
        state_d = ST_IDLE;
`ifdef IMEM_LOADER_CHECKSUM_EN
        start_up_d = cksum_err_q;
`else
        start_up_d = 1'b0;
`endif
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      count_q    <= '0;
      idx_q      <= '0;
      start_up_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      count_q    <= count_d;
      idx_q      <= idx_d;
      start_up_q <= start_up_d;
    end
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q       <= '0;
      cks_phase_q <= 1'b0;
      cksum_err_q <= 1'b0;
    end else begin
      sum_q       <= sum_d;
      cks_phase_q <= cks_phase_d;
      cksum_err_q <= cksum_err_d;
    end
  end
  assign cksum_err = cksum_err_q;
`else
  assign cksum_err = 1'b0;
`endif

  assign idx_ext    = 32'(idx_q);
  assign mem_addr   = BASE_ADDR + (idx_ext << 2);
  assign mem_din    = pk_word;
  assign mem_we     = (state_q == ST_WRITE);
  assign byte_ready = (state_q == ST_RECV);
  assign busy       = (state_q != ST_IDLE);
  assign start_up   = start_up_q;

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader with a write-queue reference model and literal spot checks.
module tb_imem_loader;

  localparam logic [31:0] BASE = 32'h0040_0020;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        load_req;
  logic [15:0] word_count;
  logic        byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, mem_we, start_up, busy, cksum_err;
  logic [31:0] mem_addr, mem_din;

  int checks   = 0;
  int failures = 0;

  logic [63:0] exp_q[$];
  logic [31:0] wr_addr[0:31];
  logic [31:0] wr_data[0:31];
  int          wr_n = 0;
  logic [7:0]  prog_b[0:31];

  imem_loader dut (
    .clk(clk), .rst_n(rst_n), .load_req(load_req), .word_count(word_count),
    .byte_valid(byte_valid), .byte_data(byte_data), .byte_ready(byte_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_din(mem_din), .start_up(start_up),
    .busy(busy), .cksum_err(cksum_err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Scoreboard: every write must match the next queued (address, word) pair.
  always @(negedge clk) begin
    if (rst_n === 1'b1) begin
`ifndef IMEM_LOADER_CHECKSUM_EN
      chk("cksum_err_tied_low", {31'b0, cksum_err}, 32'h0);
`endif
      if (mem_we === 1'b1) begin
        if (exp_q.size() == 0) begin
          checks++;
          failures++;
          $display("FAIL unexpected_write: got addr %h data %h expected no write", mem_addr, mem_din);
        end else begin
          logic [63:0] e;
          e = exp_q.pop_front();
          chk("write_addr", mem_addr, e[63:32]);
          chk("write_data", mem_din, e[31:0]);
        end
        if (wr_n < 32) begin
          wr_addr[wr_n] = mem_addr;
          wr_data[wr_n] = mem_din;
        end
        wr_n++;
      end
    end
  end

  function automatic logic [31:0] prog_word(input int i);
    return {prog_b[4*i], prog_b[4*i+1], prog_b[4*i+2], prog_b[4*i+3]};
  endfunction

  task automatic pulse_load(input logic [15:0] wc);
    load_req   = 1'b1;
    word_count = wc;
    @(negedge clk);
    load_req   = 1'b0;
    word_count = 16'hFFFF;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    byte_valid = 1'b1;
    byte_data  = b;
    while (byte_ready !== 1'b1 && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) begin
      checks++;
      failures++;
      $display("FAIL byte_timeout: got byte_ready low for %0d cycles expected high", t);
    end
    @(negedge clk);
    byte_valid = 1'b0;
    if (gap) @(negedge clk);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap);
    for (int k = 3; k >= 0; k--) send_byte(w[8*k +: 8], gap);
  endtask

  task automatic wait_idle(input string nm);
    int t = 0;
    while (busy !== 1'b0 && t < 500) begin
      @(negedge clk);
      t++;
    end
    if (t >= 500) begin
      checks++;
      failures++;
      $display("FAIL %s_timeout: got busy after %0d cycles expected idle", nm, t);
    end
  endtask

  // Streams a whole program from prog_b and queues the writes the loader must make.
  task automatic run_prog(input int wc, input bit gap, input bit bad_cks);
    logic [31:0] sum = 32'h0;
    for (int i = 0; i < wc; i++) begin
      exp_q.push_back({BASE + 32'(i) * 32'd4, prog_word(i)});
      sum = sum + prog_word(i);
    end
    pulse_load(16'(wc));
    for (int i = 0; i < wc; i++) send_word(prog_word(i), gap);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(bad_cks ? sum + 32'd1 : sum, gap);
`else
    if (bad_cks) sum = sum + 32'd1;
`endif
    wait_idle("load");
  endtask

  task automatic check_reset_outputs(input string tag);
    chk({tag, "_byte_ready"}, {31'b0, byte_ready}, 32'h0);
    chk({tag, "_mem_we"},     {31'b0, mem_we},     32'h0);
    chk({tag, "_mem_addr"},   mem_addr,            32'h0040_0020);
    chk({tag, "_mem_din"},    mem_din,             32'h0);
    chk({tag, "_start_up"},   {31'b0, start_up},   32'h1);
    chk({tag, "_busy"},       {31'b0, busy},       32'h0);
    chk({tag, "_cksum_err"},  {31'b0, cksum_err},  32'h0);
  endtask

  initial begin
    int n0;
    rst_n = 1'b0; load_req = 1'b0; word_count = 16'h0; byte_valid = 1'b0; byte_data = 8'h0;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("post_rst");

    // Two-word load with back-to-back bytes
    {prog_b[0], prog_b[1], prog_b[2], prog_b[3]} = 32'h1234_5678;
    {prog_b[4], prog_b[5], prog_b[6], prog_b[7]} = 32'h9ABC_DEF0;
    run_prog(2, 1'b0, 1'b0);
    chk("t1_writes",   32'(wr_n), 32'd2);
    chk("t1_addr0",    wr_addr[0], 32'h0040_0020);
    chk("t1_data0",    wr_data[0], 32'h1234_5678);
    chk("t1_addr1",    wr_addr[1], 32'h0040_0024);
    chk("t1_data1",    wr_data[1], 32'h9ABC_DEF0);
    chk("t1_start_up", {31'b0, start_up}, 32'h0);

    // Zero-length load, with bytes offered that must not be taken
    n0 = wr_n;
    byte_valid = 1'b1; byte_data = 8'h55;
    pulse_load(16'd0);
    chk("t2_finish_busy",     {31'b0, busy},       32'h1);
    chk("t2_finish_start_up", {31'b0, start_up},   32'h1);
    chk("t2_finish_ready",    {31'b0, byte_ready}, 32'h0);
    @(negedge clk);
    chk("t2_idle_busy",     {31'b0, busy},       32'h0);
    chk("t2_idle_start_up", {31'b0, start_up},   32'h0);
    chk("t2_idle_ready",    {31'b0, byte_ready}, 32'h0);
    byte_valid = 1'b0;
    chk("t2_no_write", 32'(wr_n - n0), 32'd0);

    // One word with gaps; a second load_req mid-word is ignored
    n0 = wr_n;
    exp_q.push_back({32'h0040_0020, 32'hAABB_CCDD});
    pulse_load(16'd1);
    send_byte(8'hAA, 1'b1);
    send_byte(8'hBB, 1'b1);
    pulse_load(16'd5);
    send_byte(8'hCC, 1'b1);
    send_byte(8'hDD, 1'b1);
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_word(32'hAABB_CCDD, 1'b1);
`endif
    wait_idle("t3");
    chk("t3_writes",   32'(wr_n - n0), 32'd1);
    chk("t3_data",     wr_data[n0], 32'hAABB_CCDD);
    chk("t3_start_up", {31'b0, start_up}, 32'h0);

    // Reset in the middle of word 0
    n0 = wr_n;
    pulse_load(16'd3);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    send_byte(8'h33, 1'b0);
    rst_n = 1'b0;
    #1;
    check_reset_outputs("t4_in_rst");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    check_reset_outputs("t4_after");
    chk("t4_no_write", 32'(wr_n - n0), 32'd0);

    // Fresh load after the aborted one: stale partial bytes must not leak in
    n0 = wr_n;
    {prog_b[0], prog_b[1], prog_b[2], prog_b[3]} = 32'hCAFE_0001;
    {prog_b[4], prog_b[5], prog_b[6], prog_b[7]} = 32'h0BAD_F00D;
    run_prog(2, 1'b0, 1'b0);
    chk("t6_writes",   32'(wr_n - n0), 32'd2);
    chk("t6_data0",    wr_data[n0], 32'hCAFE_0001);
    chk("t6_start_up", {31'b0, start_up}, 32'h0);

`ifdef IMEM_LOADER_CHECKSUM_EN
    // Checksum good then bad
    {prog_b[0], prog_b[1], prog_b[2], prog_b[3]} = 32'h0000_0001;
    {prog_b[4], prog_b[5], prog_b[6], prog_b[7]} = 32'h0000_0002;
    run_prog(2, 1'b0, 1'b0);
    chk("t5_good_err",      {31'b0, cksum_err}, 32'h0);
    chk("t5_good_start_up", {31'b0, start_up},  32'h0);
    run_prog(2, 1'b0, 1'b1);
    chk("t5_bad_err",      {31'b0, cksum_err}, 32'h1);
    chk("t5_bad_start_up", {31'b0, start_up},  32'h1);
    pulse_load(16'd0);
    chk("t5_err_cleared", {31'b0, cksum_err}, 32'h0);
    @(negedge clk);
    chk("t5_release", {31'b0, start_up}, 32'h0);
`endif

    chk("pending_writes", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish expected finish");
    $fatal(1);
  end

endmodule
